mips_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the mipscomputer data bus, downstream of the CPU store path.

---
 rtl/mips_uart_tx.sv | 214 +++++++++++++++++++++
 tb/tb_mips_uart_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_uart_tx.sv
// rtl/mips_uart_tx.sv - memory-mapped 8N1 UART transmitter with a small TX FIFO
//
// Stores from the CPU to BASE_ADDR queue a byte in the TX FIFO. The serialiser
// drains the FIFO one byte at a time and sends each byte as start, 8 data bits
// (LSB first) and stop. Each bit lasts CLKS_PER_BIT clocks.
// A store to BASE_ADDR+4 clears the sticky overflow flag.
//
// Ports:
//   clock       single clock, all state changes on posedge
//   reset       synchronous, active-high
//   address     CPU data address
//   write_data  CPU store data; [7:0] is the byte for TXDATA
//   mem_write   CPU store strobe, one cycle per store
//   sel         combinational; high when address hits TXDATA or STATUS
//   read_data   combinational; STATUS {29'b0, overflow, busy, full} at BASE_ADDR+4, else 0
//   tx          registered serial output, idle high
module mips_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    output logic        sel,
    output logic [31:0] read_data,
    output logic        tx
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] CLK_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   COUNT_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    // Serialiser state
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;

    logic is_data;
    logic is_status;
    logic full;
    logic busy;
    logic push;
    logic drop;
    logic clr;
    logic pop;
    logic bit_done;

    // Address decode and register read path
    assign is_data   = (address == BASE_ADDR);
    assign is_status = (address == STATUS_ADDR);
    assign sel       = is_data | is_status;

    assign full = (count_q == COUNT_FULL);
    assign busy = (state_q != S_IDLE) | (count_q != '0);

    assign read_data = is_status ? {29'b0, ovf_q, busy, full} : 32'b0;

    // full is taken from the registered count, so a store that arrives while
    // full is dropped even if the serialiser pops on the same edge.
    assign push = mem_write & is_data & ~full;
    assign drop = mem_write & is_data & full;
    assign clr  = mem_write & is_status;

    // The serialiser only takes a byte from IDLE; the FIFO head is loaded
    // into the shift register on the same edge the start bit begins.
    assign pop = (state_q == S_IDLE) & (count_q != '0);

    assign bit_done = (clk_cnt_q == CLK_LAST);

    assign tx = tx_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        count_d = count_q;
        ovf_d = ovf_q;

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        // Drop and clear target different addresses, so they never coincide.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d = shift_q;
        tx_d = tx_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d = fifo_mem_q[rptr_q];
                    tx_d = 1'b0;
                    clk_cnt_d = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = 3'd0;
                    tx_d = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            S_DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // The bit on the line is always shift_q[0]; the next one
                        // is shift_q[1] and becomes the new LSB after the shift.
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d = shift_q[1];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            S_STOP: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    state_d = S_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end

            default: begin
                tx_d = 1'b1;
                clk_cnt_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            count_q <= '0;
            state_q <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= 3'd0;
            shift_q <= 8'd0;
            tx_q <= 1'b1;
            ovf_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q <= shift_d;
            tx_q <= tx_d;
            ovf_q <= ovf_d;
        end
    end

    // FIFO contents need no reset; the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            fifo_mem_q[wptr_q] <= write_data[7:0];
        end
    end

endmodule

// File: tb/tb_mips_uart_tx.sv
// tb/tb_mips_uart_tx.sv - self-checking bench for mips_uart_tx
module tb_mips_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam logic [31:0] A_DATA = 32'h0000_FF00;
    localparam logic [31:0] A_STAT = 32'h0000_FF04;
    localparam logic [31:0] A_OTHR = 32'h0000_FF08;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        mem_write = 1'b0;
    logic        sel;
    logic [31:0] read_data;
    logic        tx;

    always #5 clock = ~clock;

    mips_uart_tx #(
        .BASE_ADDR   (A_DATA),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .write_data(write_data),
        .mem_write (mem_write),
        .sel       (sel),
        .read_data (read_data),
        .tx        (tx)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bytes waiting, the frame currently on the line (which
    // edge it started at) and the earliest edge the next frame may start.
    logic [7:0] mq[$];
    logic [7:0] cur = 8'h00;
    bit         have_frame = 1'b0;
    bit         ovf = 1'b0;
    bit         settled = 1'b0;
    int         cyc = 0;
    int         pop_c = 0;
    int         ready = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_frame();
        return have_frame && (cyc - pop_c) < FRAME;
    endfunction

    function automatic logic exp_tx();
        int k;
        if (!in_frame()) return 1'b1;
        k = (cyc - pop_c) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        bit busy;
        bit full;
        busy = (mq.size() != 0) || in_frame();
        full = (mq.size() == DEPTH);
        return {29'b0, ovf, busy, full};
    endfunction

    task automatic model_edge(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit full_b;
        if (r) begin
            mq.delete();
            ovf = 1'b0;
            have_frame = 1'b0;
            ready = 0;
            settled = 1'b1;
        end else begin
            full_b = (mq.size() == DEPTH);
            if (mq.size() != 0 && cyc >= ready) begin
                cur = mq.pop_front();
                have_frame = 1'b1;
                pop_c = cyc;
                ready = cyc + FRAME + 1;
            end
            if (w && a == A_DATA) begin
                if (full_b) ovf = 1'b1;
                else mq.push_back(d[7:0]);
            end
            if (w && a == A_STAT) ovf = 1'b0;
        end
    endtask

    task automatic cycle(input bit w, input logic [31:0] a, input logic [31:0] d, input bit r);
        reset = r;
        mem_write = w;
        address = a;
        write_data = d;
        #1;
        chk("sel", {31'b0, sel}, {31'b0, (a == A_DATA) || (a == A_STAT)});
        if (settled) begin
            chk("read_data", read_data, (a == A_STAT) ? exp_status() : 32'h0);
        end
        @(posedge clock);
        cyc++;
        model_edge(r, w, a, d);
        #1;
        chk("tx", {31'b0, tx}, {31'b0, exp_tx()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, A_STAT, 32'h0, 1'b0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cycle(1'b1, a, d, 1'b0);
    endtask

    task automatic peek(input string tag, input logic [31:0] exp);
        mem_write = 1'b0;
        address = A_STAT;
        #1;
        chk(tag, read_data, exp);
    endtask

    initial begin
        // Bring-up reset
        for (int i = 0; i < 2; i++) cycle(1'b0, A_STAT, 32'h0, 1'b1);
        chk("reset_tx", {31'b0, tx}, 32'h1);
        peek("reset_status", 32'h0);
        idle(3);

        // Single 0x55 frame with explicit timing points
        store(A_DATA, 32'h0000_0055);
        idle(1);
        chk("t2_start", {31'b0, tx}, 32'h0);
        peek("t2_busy", 32'h2);
        idle(35);
        chk("t2_bit7", {31'b0, tx}, 32'h0);
        idle(1);
        chk("t2_stop", {31'b0, tx}, 32'h1);
        idle(3);
        peek("t2_busy_end", 32'h2);
        idle(1);
        peek("t2_idle", 32'h0);
        idle(4);

        // Two back-to-back frames
        store(A_DATA, 32'h0000_0041);
        store(A_DATA, 32'h0000_0042);
        idle(90);

        // Six stores: fifth fills the FIFO, sixth overflows
        for (int i = 0; i < 6; i++) store(A_DATA, 32'h0000_0060 + i);
        peek("t4_status", 32'h7);
        store(A_STAT, 32'hFFFF_FFFF);
        peek("t4_cleared", 32'h3);
        idle(5 * (FRAME + 1) + 5);
        peek("t4_drained", 32'h0);

        // Reset held 3 cycles mid-stream
        store(A_DATA, 32'h0000_00C3);
        store(A_DATA, 32'h0000_003C);
        idle(12);
        for (int i = 0; i < 3; i++) cycle(1'b0, A_STAT, 32'h0, 1'b1);
        chk("t1_tx", {31'b0, tx}, 32'h1);
        idle(1);
        peek("t1_status", 32'h0);
        idle(20);

        // Reset during DATA with two bytes queued
        store(A_DATA, 32'h0000_00A5);
        store(A_DATA, 32'h0000_0011);
        store(A_DATA, 32'h0000_0022);
        idle(9);
        cycle(1'b0, A_STAT, 32'h0, 1'b1);
        chk("t5_tx", {31'b0, tx}, 32'h1);
        idle(60);
        peek("t5_status", 32'h0);

        // Other addresses
        store(A_OTHR, 32'h0000_00AA);
        cycle(1'b0, A_DATA, 32'h0, 1'b0);
        chk("t6_sel", {31'b0, sel}, 32'h1);
        chk("t6_rd", read_data, 32'h0);
        peek("t6_nopush", 32'h0);
        idle(5);

        // Randomized traffic against the model
        for (int i = 0; i < 700; i++) begin
            bit r;
            bit w;
            logic [31:0] a;
            r = ($urandom_range(0, 199) == 0);
            w = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0, 1:    a = A_DATA;
                2:       a = A_STAT;
                3:       a = A_OTHR;
                default: a = $urandom;
            endcase
            cycle(w, a, $urandom, r);
        end
        idle(5 * (FRAME + 1) + 5);
        peek("final_status", {29'b0, ovf, 2'b00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
